// File: rtl/qammod_sched.sv
// qammod_sched: round-robin symbol scheduler sharing one qammod between
// N_REQ packet sources. The winner of an arbitration keeps its grant for
// the whole packet. A packet that reaches MAX_BURST words is cut there.
// Issued symbols are registered and tagged with their source id.
// Optional feature macro: QAMMOD_SCHED_IDLE_FILL_EN. When it is defined,
// every strobe cycle without a transfer emits a fill symbol with
// o_id == N_REQ.
module qammod_sched #(
  parameter int MODULATION_ORDER = 64,
  parameter int N_REQ            = 4,
  parameter int MAX_BURST        = 256,
  localparam int S_W             = 2 * $clog2(MODULATION_ORDER),
  localparam int ID_W            = $clog2(N_REQ + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stb,
  input  logic [N_REQ-1:0]     i_valid,
  input  logic [N_REQ*S_W-1:0] i_s,
  input  logic [N_REQ-1:0]     i_last,
  output logic [N_REQ-1:0]     o_ready,
  output logic                 o_dv,
  output logic [S_W-1:0]       o_s,
  output logic [ID_W-1:0]      o_id,
  output logic                 o_last,
  output logic                 o_cut,
  output logic                 o_underrun
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   owner_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [PTR_W:0]     cand_w_s;
  logic [PTR_W-1:0]   cand_s;
  logic               hit_s;
  logic               win_found_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic               grant_vld_s;
  logic               xfer_s;
  logic [S_W-1:0]     sel_word_s;
  logic               sel_last_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               at_max_s;
  logic               burst_s;
  logic               cut_s;
  logic               underrun_s;
  logic [N_REQ-1:0]   ready_s;

  // Next requester index after idx, wrapping at N_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == PTR_W'(N_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Round-robin search: the first valid requester at or after ptr wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_w_s    = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_w_s    = {1'b0, ptr_r} + (PTR_W + 1)'(i);
      cand_w_s    = (cand_w_s >= (PTR_W + 1)'(N_REQ)) ?
                    (cand_w_s - (PTR_W + 1)'(N_REQ)) : cand_w_s;
      cand_s      = cand_w_s[PTR_W-1:0];
      hit_s       = ~win_found_s & i_valid[cand_s];
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Grant selection, transfer qualification and burst bookkeeping.
  always_comb begin
    grant_idx_s = '0;
    grant_vld_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_idx_s = win_idx_s;
        grant_vld_s = win_found_s;
      end
      ST_BURST: begin
        grant_idx_s = owner_r;
        grant_vld_s = 1'b1;
      end
      default: begin
        grant_idx_s = '0;
        grant_vld_s = 1'b0;
      end
    endcase
    xfer_s     = i_stb & grant_vld_s & i_valid[grant_idx_s];
    sel_word_s = i_s[int'(grant_idx_s) * S_W +: S_W];
    sel_last_s = i_last[grant_idx_s];
    cnt_inc_s  = cnt_r + CNT_W'(1);
    at_max_s   = (cnt_inc_s == CNT_W'(MAX_BURST));
    burst_s    = (state_r == ST_BURST);
    cut_s      = burst_s & xfer_s & ~sel_last_s & at_max_s;
    underrun_s = burst_s & i_stb & ~i_valid[owner_r];
    ready_s    = '0;
    // Ready is also held off while reset is asserted, so that no word is
    // taken while the flops are being cleared.
    if (rst & i_stb & grant_vld_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign o_ready = ready_s;

  // Arbitration FSM and registered modulator-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      cnt_r      <= '0;
      o_dv       <= 1'b0;
      o_s        <= '0;
      o_id       <= '0;
      o_last     <= 1'b0;
      o_cut      <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            if (sel_last_s) begin
              ptr_r <= wrap_inc(grant_idx_s);
            end else begin
              state_r <= ST_BURST;
              owner_r <= grant_idx_s;
              cnt_r   <= CNT_W'(1);
            end
          end
        end
        ST_BURST: begin
          if (xfer_s) begin
            cnt_r <= cnt_inc_s;
            // A cut packet's remainder re-arbitrates as a new packet.
            if (sel_last_s | at_max_s) begin
              state_r <= ST_IDLE;
              ptr_r   <= wrap_inc(owner_r);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      o_cut      <= cut_s;
      o_underrun <= underrun_s;
      if (xfer_s) begin
        o_dv   <= 1'b1;
        o_s    <= sel_word_s;
        o_id   <= ID_W'(grant_idx_s);
        o_last <= sel_last_s | cut_s;
      end
`ifdef QAMMOD_SCHED_IDLE_FILL_EN
      else if (i_stb) begin
        // Keep the modulator stream continuous at the strobe rate.
        o_dv   <= 1'b1;
        o_s    <= '0;
        o_id   <= ID_W'(N_REQ);
        o_last <= 1'b0;
      end
`endif
      else begin
        o_dv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qammod_sched.sv
// Directed testbench for qammod_sched: N_REQ=4, S_W=8, MAX_BURST=4.
module tb_qammod_sched;

`ifdef QAMMOD_SCHED_IDLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stb;
  logic [3:0]  valid;
  logic [31:0] s_bus;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic        dv;
  logic [7:0]  s;
  logic [2:0]  id;
  logic        olast;
  logic        cut;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;

  qammod_sched #(
    .MODULATION_ORDER(16),
    .N_REQ(4),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_stb(stb),
    .i_valid(valid),
    .i_s(s_bus),
    .i_last(last),
    .o_ready(ready),
    .o_dv(dv),
    .o_s(s),
    .o_id(id),
    .o_last(olast),
    .o_cut(cut),
    .o_underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [7:0] v, input logic l);
    s_bus[k*8 +: 8] = v;
    last[k] = l;
  endtask

  task automatic check_out(input string tag, input logic e_dv, input logic [7:0] e_s,
                           input logic [2:0] e_id, input logic e_last);
    check({tag, ".dv"}, 32'(dv), 32'(e_dv));
    check({tag, ".s"}, 32'(s), 32'(e_s));
    check({tag, ".id"}, 32'(id), 32'(e_id));
    check({tag, ".last"}, 32'(olast), 32'(e_last));
  endtask

  task automatic do_reset();
    valid = 4'h0;
    last  = 4'h0;
    stb   = 1'b1;
    rst   = 1'b0;
    #2;
    rst   = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stb = 1'b1; valid = 4'h0; last = 4'h0; s_bus = 32'h0;
    #3;
    check_out("por", 1'b0, 8'h00, 3'd0, 1'b0);
    check("por.cut", 32'(cut), 32'd0);
    check("por.ready", 32'(ready), 32'd0);
    tick();
    rst = 1'b1;

    // Reset mid-burst: source 1 in the middle of a 3-word packet.
    valid = 4'b0010;
    set_word(1, 8'h11, 1'b0);
    #1; check("rst.ready0", 32'(ready), 32'b0010);
    tick();
    check_out("rst.w0", 1'b1, 8'h11, 3'd1, 1'b0);
    set_word(1, 8'h12, 1'b0);
    tick();
    check_out("rst.w1", 1'b1, 8'h12, 3'd1, 1'b0);
    #2; rst = 1'b0;
    #1;
    check_out("rst.async", 1'b0, 8'h00, 3'd0, 1'b0);
    check("rst.async.ready", 32'(ready), 32'd0);
    #1; rst = 1'b1;
    // Source 0 now wins from ptr=0, which shows the grant was dropped.
    valid = 4'b0011;
    set_word(0, 8'h05, 1'b1);
    set_word(1, 8'h13, 1'b1);
    #1; check("rst.rearb.ready", 32'(ready), 32'b0001);
    tick();
    check_out("rst.rearb0", 1'b1, 8'h05, 3'd0, 1'b1);
    valid = 4'b0010;
    #1; check("rst.rearb1.ready", 32'(ready), 32'b0010);
    tick();
    check_out("rst.rearb1", 1'b1, 8'h13, 3'd1, 1'b1);
    valid = 4'b0000;
    tick();
    check_out("idle", FILL, FILL ? 8'h00 : 8'h13, FILL ? 3'd4 : 3'd1, FILL ? 1'b0 : 1'b1);

    // Round-robin over four 1-word packets.
    do_reset();
    valid = 4'b1111;
    set_word(0, 8'h10, 1'b1);
    set_word(1, 8'h21, 1'b1);
    set_word(2, 8'h32, 1'b1);
    set_word(3, 8'h43, 1'b1);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] e_s;
      logic [3:0] e_rdy;
      e_s   = (k % 4 == 0) ? 8'h10 : (k % 4 == 1) ? 8'h21 : (k % 4 == 2) ? 8'h32 : 8'h43;
      e_rdy = 4'b0001 << (k % 4);
      #1; check($sformatf("rr%0d.ready", k), 32'(ready), 32'(e_rdy));
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, e_s, 3'(k % 4), 1'b1);
    end

    // Packet lock: source 0 waits for source 2's whole packet.
    do_reset();
    valid = 4'b0100;
    set_word(2, 8'h2A, 1'b0);
    #1; check("lock0.ready", 32'(ready), 32'b0100);
    tick();
    check_out("lock0", 1'b1, 8'h2A, 3'd2, 1'b0);
    valid = 4'b0101;
    set_word(0, 8'h0B, 1'b1);
    set_word(2, 8'h2B, 1'b0);
    #1; check("lock1.ready", 32'(ready), 32'b0100);
    tick();
    check_out("lock1", 1'b1, 8'h2B, 3'd2, 1'b0);
    set_word(2, 8'h2C, 1'b1);
    #1; check("lock2.ready", 32'(ready), 32'b0100);
    tick();
    check_out("lock2", 1'b1, 8'h2C, 3'd2, 1'b1);
    valid = 4'b0001;
    #1; check("lock3.ready", 32'(ready), 32'b0001);
    tick();
    check_out("lock3", 1'b1, 8'h0B, 3'd0, 1'b1);

    // Burst cut at MAX_BURST=4, then source 0, then source 3 resumes.
    do_reset();
    valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      set_word(3, 8'h30 + 8'(k), 1'b0);
      if (k == 1) begin
        valid = 4'b1001;
        set_word(0, 8'h0C, 1'b1);
      end
      #1; check($sformatf("cut%0d.ready", k), 32'(ready), 32'b1000);
      tick();
      check_out($sformatf("cut%0d", k), 1'b1, 8'h30 + 8'(k), 3'd3, k == 3);
      check($sformatf("cut%0d.cut", k), 32'(cut), 32'(k == 3));
    end
    set_word(3, 8'h34, 1'b0);
    #1; check("cut.src0.ready", 32'(ready), 32'b0001);
    tick();
    check_out("cut.src0", 1'b1, 8'h0C, 3'd0, 1'b1);
    check("cut.src0.cut", 32'(cut), 32'd0);
    valid = 4'b1000;
    #1; check("cut.resume.ready", 32'(ready), 32'b1000);
    tick();
    check_out("cut.resume", 1'b1, 8'h34, 3'd3, 1'b0);

    // Strobe throttle: strobe on every 4th cycle.
    do_reset();
    valid = 4'b0010;
    set_word(1, 8'hA5, 1'b0);
    for (int c = 0; c < 8; c++) begin
      stb = (c % 4 == 0);
      if (c == 1) set_word(1, 8'h5A, 1'b1);
      #1; check($sformatf("thr%0d.ready", c), 32'(ready), (c % 4 == 0) ? 32'b0010 : 32'b0000);
      tick();
      check($sformatf("thr%0d.dv", c), 32'(dv), 32'(c % 4 == 0));
      check($sformatf("thr%0d.ur", c), 32'(underrun), 32'd0);
      if (c % 4 == 0) check($sformatf("thr%0d.s", c), 32'(s), (c == 0) ? 32'hA5 : 32'h5A);
    end

    // Underrun mid-packet, with or without fill.
    do_reset();
    valid = 4'b0001;
    set_word(0, 8'h01, 1'b0);
    tick();
    check_out("ur0", 1'b1, 8'h01, 3'd0, 1'b0);
    valid = 4'b0000;
    #1; check("ur1.ready", 32'(ready), 32'b0001);
    tick();
    check("ur1.underrun", 32'(underrun), 32'd1);
    check_out("ur1", FILL, FILL ? 8'h00 : 8'h01, FILL ? 3'd4 : 3'd0, 1'b0);
    valid = 4'b0001;
    set_word(0, 8'h02, 1'b1);
    tick();
    check("ur2.underrun", 32'(underrun), 32'd0);
    check_out("ur2", 1'b1, 8'h02, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
